// File: rtl/frame_extremes_tracker.sv
// Frame max/min/argmax tracker driving a shared external 8-bit magnitude comparator.
// Each sample after the first takes one CMP_MAX and one CMP_MIN cycle through the comparator.
module frame_extremes_tracker #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [7:0]       iData,
  input  logic             iValid,
  output logic             oReady,
  output logic [7:0]       oCmp_a,
  output logic [7:0]       oCmp_b,
  input  logic [2:0]       iCmp,
  output logic [7:0]       oMax,
  output logic [7:0]       oMin,
  output logic [CNT_W-1:0] oMaxIdx,
  output logic             oDone,
  output logic             oCmpErr
);

  // state   | meaning
  // IDLE    | waiting for a sample; first sample of a frame seeds max/min
  // CMP_MAX | comparator sees sample vs running max
  // CMP_MIN | comparator sees sample vs running min
  // DONE    | results published, oDone high
  typedef enum logic [1:0] {IDLE, CMP_MAX, CMP_MIN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] maxIdx;
  logic [7:0]       sample;
  logic [7:0]       maxVal;
  logic [7:0]       minVal;
  logic             cmpOneHot;

  assign cmpOneHot = (iCmp == 3'b100) || (iCmp == 3'b010) || (iCmp == 3'b001);
  assign oReady    = (state == IDLE);

  always_comb begin
    oCmp_a = 8'd0;
    oCmp_b = 8'd0;
    case (state)
      CMP_MAX: begin
        oCmp_a = sample;
        oCmp_b = maxVal;
      end
      CMP_MIN: begin
        oCmp_a = sample;
        oCmp_b = minVal;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      maxIdx  <= '0;
      sample  <= 8'd0;
      maxVal  <= 8'd0;
      minVal  <= 8'd0;
      oMax    <= 8'd0;
      oMin    <= 8'd0;
      oMaxIdx <= '0;
      oDone   <= 1'b0;
      oCmpErr <= 1'b0;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (iValid) begin
            if (cnt == '0) begin
              maxVal  <= iData;
              minVal  <= iData;
              maxIdx  <= '0;
              oCmpErr <= 1'b0;
              if (FRAME_LEN == 1) begin
                oMax    <= iData;
                oMin    <= iData;
                oMaxIdx <= '0;
                oDone   <= 1'b1;
                state   <= DONE;
              end else begin
                cnt <= CNT_W'(1);
              end
            end else begin
              sample <= iData;
              state  <= CMP_MAX;
            end
          end
        end
        CMP_MAX: begin
          // Equal results never update, so the earliest maximum keeps its index.
          if (iCmp == 3'b100) begin
            maxVal <= sample;
            maxIdx <= cnt;
          end
          if (!cmpOneHot) oCmpErr <= 1'b1;
          state <= CMP_MIN;
        end
        CMP_MIN: begin
          if (iCmp == 3'b001) minVal <= sample;
          if (!cmpOneHot) oCmpErr <= 1'b1;
          if (cnt == LAST) begin
            // Publish together with oDone; the min update of this compare is folded in.
            oMax    <= maxVal;
            oMaxIdx <= maxIdx;
            oMin    <= (iCmp == 3'b001) ? sample : minVal;
            oDone   <= 1'b1;
            state   <= DONE;
          end else begin
            cnt   <= cnt + CNT_W'(1);
            state <= IDLE;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_extremes_tracker.sv
// Directed bench for frame_extremes_tracker: FRAME_LEN=8 instance plus a FRAME_LEN=1 instance.
module tb_frame_extremes_tracker;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  always #5 clk = ~clk;

  // FRAME_LEN = 8 instance
  logic [7:0] iData = 8'd0;
  logic       iValid = 1'b0;
  logic       oReady;
  logic [7:0] cmpA, cmpB;
  logic [2:0] cmpRes;
  logic [7:0] oMax, oMin;
  logic [3:0] oMaxIdx;
  logic       oDone, oCmpErr;
  logic       forceEn = 1'b0;

  assign cmpRes = forceEn ? 3'b110 : {cmpA > cmpB, cmpA == cmpB, cmpA < cmpB};

  frame_extremes_tracker #(.FRAME_LEN(8), .CNT_W(4)) dut (
    .iClk(clk), .iRst_n(rstN), .iData(iData), .iValid(iValid), .oReady(oReady),
    .oCmp_a(cmpA), .oCmp_b(cmpB), .iCmp(cmpRes), .oMax(oMax), .oMin(oMin),
    .oMaxIdx(oMaxIdx), .oDone(oDone), .oCmpErr(oCmpErr)
  );

  // FRAME_LEN = 1 instance
  logic [7:0] d1Data = 8'd0;
  logic       d1Valid = 1'b0;
  logic       d1Ready;
  logic [7:0] d1CmpA, d1CmpB;
  logic [2:0] d1CmpRes;
  logic [7:0] d1Max, d1Min;
  logic [3:0] d1MaxIdx;
  logic       d1Done, d1CmpErr;

  assign d1CmpRes = {d1CmpA > d1CmpB, d1CmpA == d1CmpB, d1CmpA < d1CmpB};

  frame_extremes_tracker #(.FRAME_LEN(1), .CNT_W(4)) dut1 (
    .iClk(clk), .iRst_n(rstN), .iData(d1Data), .iValid(d1Valid), .oReady(d1Ready),
    .oCmp_a(d1CmpA), .oCmp_b(d1CmpB), .iCmp(d1CmpRes), .oMax(d1Max), .oMin(d1Min),
    .oMaxIdx(d1MaxIdx), .oDone(d1Done), .oCmpErr(d1CmpErr)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // oDone monitors, sampled 1 time unit after the rising edge
  int         cyc = 0;
  int         doneCnt = 0;
  int         doneCyc [64];
  logic [7:0] capMax [64];
  logic [7:0] capMin [64];
  logic [3:0] capIdx [64];
  logic       capErr [64];
  logic       capRdy [64];
  int         d1DoneCnt = 0;
  int         d1DoneCyc [8];
  logic [7:0] d1CapMax [8];
  logic [7:0] d1CapMin [8];
  logic [3:0] d1CapIdx [8];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (oDone) begin
      doneCyc[doneCnt % 64] = cyc;
      capMax[doneCnt % 64]  = oMax;
      capMin[doneCnt % 64]  = oMin;
      capIdx[doneCnt % 64]  = oMaxIdx;
      capErr[doneCnt % 64]  = oCmpErr;
      capRdy[doneCnt % 64]  = oReady;
      doneCnt++;
    end
    if (d1Done) begin
      d1DoneCyc[d1DoneCnt % 8] = cyc;
      d1CapMax[d1DoneCnt % 8]  = d1Max;
      d1CapMin[d1DoneCnt % 8]  = d1Min;
      d1CapIdx[d1DoneCnt % 8]  = d1MaxIdx;
      d1DoneCnt++;
    end
  end

  // Present a sample at a falling edge and return at the falling edge after it transfers.
  task automatic push(input logic [7:0] d);
    int guard = 0;
    iData  = d;
    iValid = 1'b1;
    while (!oReady && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      total++;
      $display("FAIL ready_timeout: oReady stayed %0d, required 1", oReady);
    end
    @(negedge clk);
  endtask

  task automatic waitDone(input int base);
    int guard = 0;
    while (doneCnt == base && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("done_seen", int'(doneCnt > base), 1);
    @(negedge clk);
    check("single_done_pulse", doneCnt - base, 1);
  endtask

  typedef struct {
    logic [7:0][7:0] s;
    logic [7:0]      expMax;
    logic [7:0]      expMin;
    logic [3:0]      expIdx;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7,
                              input logic [7:0] mx, mn, input logic [3:0] ix);
    vec_t v;
    v.s      = {a7, a6, a5, a4, a3, a2, a1, a0};
    v.expMax = mx;
    v.expMin = mn;
    v.expIdx = ix;
    return v;
  endfunction

  vec_t vecs [5];

  initial begin
    int base;
    logic [7:0] seq [8];

    vecs[0] = mk(5, 200, 17, 200, 0, 99, 255, 3,  255, 0, 6);
    vecs[1] = mk(7, 7, 7, 7, 7, 7, 7, 7,          7,   7, 0);
    vecs[2] = mk(1, 2, 3, 4, 5, 6, 7, 8,          8,   1, 7);
    vecs[3] = mk(8, 7, 6, 5, 4, 3, 2, 1,          8,   1, 0);
    vecs[4] = mk(10, 10, 3, 50, 50, 3, 49, 50,    50,  3, 3);

    // Reset with a sample on the bus: it must be ignored
    iData = 8'd77;
    iValid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_max", oMax, 0);
    check("rst_min", oMin, 0);
    check("rst_ready", oReady, 1);
    check("rst_cmpA", cmpA, 0);
    iValid = 1'b0;
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idx", oMaxIdx, 0);
    check("post_rst_done", oDone, 0);
    check("post_rst_err", oCmpErr, 0);

    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      base = doneCnt;
      for (int k = 0; k < 8; k++) push(vecs[v].s[k]);
      iValid = 1'b0;
      waitDone(base);
      check($sformatf("vec%0d_max", v), oMax, vecs[v].expMax);
      check($sformatf("vec%0d_min", v), oMin, vecs[v].expMin);
      check($sformatf("vec%0d_idx", v), oMaxIdx, vecs[v].expIdx);
      check($sformatf("vec%0d_err", v), oCmpErr, 0);
      check($sformatf("vec%0d_hold", v), oDone, 0);
    end

    // Back-to-back frames, iValid held high: 1..8 then 8..1
    base = doneCnt;
    push(8'd1);
    push(8'd2);
    check("b2b_cmax_ready", oReady, 0);
    check("b2b_cmax_a", cmpA, 2);
    check("b2b_cmax_b", cmpB, 1);
    @(negedge clk);
    check("b2b_cmin_ready", oReady, 0);
    check("b2b_cmin_b", cmpB, 1);
    @(negedge clk);
    check("b2b_idle_ready", oReady, 1);
    for (int k = 3; k <= 8; k++) push(8'(k));
    for (int k = 8; k >= 1; k--) push(8'(k));
    iValid = 1'b0;
    repeat (6) @(negedge clk);
    check("b2b_done_count", doneCnt - base, 2);
    check("b2b_period", doneCyc[(base + 1) % 64] - doneCyc[base % 64], 23);
    check("b2b_done_ready", capRdy[base % 64], 0);
    check("b2b_f1_max", capMax[base % 64], 8);
    check("b2b_f1_idx", capIdx[base % 64], 7);
    check("b2b_f2_max", capMax[(base + 1) % 64], 8);
    check("b2b_f2_min", capMin[(base + 1) % 64], 1);
    check("b2b_f2_idx", capIdx[(base + 1) % 64], 0);

    // Invalid comparator result during CMP_MAX of sample 3
    seq = '{8'd5, 8'd20, 8'd17, 8'd250, 8'd0, 8'd99, 8'd1, 8'd3};
    base = doneCnt;
    for (int k = 0; k < 8; k++) begin
      push(seq[k]);
      if (k == 3) begin
        check("err_before", oCmpErr, 0);
        forceEn = 1'b1;
        @(negedge clk);
        forceEn = 1'b0;
        check("err_rise", oCmpErr, 1);
      end
    end
    iValid = 1'b0;
    waitDone(base);
    check("err_at_done", capErr[base % 64], 1);
    check("err_max", oMax, 99);
    check("err_idx", oMaxIdx, 5);
    check("err_min", oMin, 0);
    check("err_sticky", oCmpErr, 1);
    base = doneCnt;
    push(8'd7);
    check("err_clear", oCmpErr, 0);
    for (int k = 1; k < 8; k++) push(8'd7);
    iValid = 1'b0;
    waitDone(base);
    check("err_next_max", oMax, 7);

    // Reset after the 4th sample, then a clean frame
    push(8'd250);
    push(8'd0);
    push(8'd3);
    push(8'd4);
    rstN = 1'b0;
    #1;
    check("midrst_max", oMax, 0);
    check("midrst_min", oMin, 0);
    check("midrst_cmpA", cmpA, 0);
    check("midrst_cmpB", cmpB, 0);
    check("midrst_ready", oReady, 1);
    @(negedge clk);
    @(negedge clk);
    iValid = 1'b0;
    rstN = 1'b1;
    @(negedge clk);
    seq = '{8'd9, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    base = doneCnt;
    for (int k = 0; k < 8; k++) push(seq[k]);
    iValid = 1'b0;
    waitDone(base);
    check("postrst_max", oMax, 9);
    check("postrst_min", oMin, 1);
    check("postrst_idx", oMaxIdx, 0);

    // FRAME_LEN=1 instance: 42 then 13 back-to-back
    base = d1DoneCnt;
    seq[0] = 8'd42;
    seq[1] = 8'd13;
    for (int k = 0; k < 2; k++) begin
      int guard = 0;
      d1Data  = seq[k];
      d1Valid = 1'b1;
      while (!d1Ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 20) begin
        total++;
        $display("FAIL fl1_ready_timeout: ready %0d, required 1", d1Ready);
      end
      @(negedge clk);
    end
    d1Valid = 1'b0;
    repeat (3) @(negedge clk);
    check("fl1_done_count", d1DoneCnt - base, 2);
    check("fl1_period", d1DoneCyc[(base + 1) % 8] - d1DoneCyc[base % 8], 2);
    check("fl1_f1_max", d1CapMax[base % 8], 42);
    check("fl1_f1_min", d1CapMin[base % 8], 42);
    check("fl1_f2_max", d1CapMax[(base + 1) % 8], 13);
    check("fl1_f2_min", d1CapMin[(base + 1) % 8], 13);
    check("fl1_idx", d1CapIdx[(base + 1) % 8], 0);
    check("fl1_err", d1CmpErr, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: time %0t, required finish earlier", $time);
    $fatal(1);
  end

endmodule
